pipelined_carry_adder: RTL

//   Parametrised, pipelined multi-bit adder that generalises the 1-bit full adder.
//   - Computes {c_out, sum} = a + b + c_in over WIDTH bits.
//   - The carry chain is split into STAGES registered slices.
//   - A valid/ready handshake moves one operation per cycle; out_ready applies back-pressure.
//   - Used as the arithmetic datapath building block for counters and checksum units in the
//     I2C slave and peripheral blocks.

---
 rtl/pipelined_carry_adder_pkg.sv | 12 +
 rtl/pipelined_carry_adder_slice.sv | 31 +++
 rtl/pipelined_carry_adder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for the pipelined carry adder: slice width and reset constants.
package adder_pkg;

    localparam logic SUM_RESET_BIT = 1'b0;

    // Returns 0 when WIDTH cannot be split evenly, which the top level treats as fatal.
    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        if (stages == 0 || width % stages != 0) return 0;
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_carry_adder_slice.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; exposes the MSB carry-in
// so the top level can derive signed overflow.
module adder_slice
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             msb_c_in
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out    = carry[CHUNK];
    assign msb_c_in = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit adder with STAGES registered carry slices and a valid/ready handshake.
// Define ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (CHUNK == 0) begin : g_bad_params
        $fatal(1, "pipelined_carry_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Global stall: the whole pipeline moves only when the output slot is free or being taken.
    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage k sees only the operand bits its own and later slices still need, and
        // the already-finished lower sum chunks it must carry along.
        localparam int unsigned SRC_W = WIDTH - k * CHUNK;
        localparam int unsigned SUM_W = (k + 1) * CHUNK;

        logic [SRC_W-1:0] a_src;
        logic [SRC_W-1:0] b_src;
        logic             carry_src;
        logic             valid_src;
        logic [SUM_W-1:0] sum_next;
        logic [CHUNK-1:0] slice_sum;
        logic             slice_c_out;
        logic             msb_cin;
        logic [SUM_W-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        if (k == 0) begin : g_head
            assign a_src     = a;
            assign b_src     = b;
            assign carry_src = c_in;
            assign valid_src = in_valid & in_ready;
            assign sum_next  = slice_sum;
        end else begin : g_tail
            assign a_src     = g_stage[k-1].g_skew.a_q;
            assign b_src     = g_stage[k-1].g_skew.b_q;
            assign carry_src = g_stage[k-1].carry_q;
            assign valid_src = g_stage[k-1].valid_q;
            assign sum_next  = {slice_sum, g_stage[k-1].sum_q};
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (a_src[CHUNK-1:0]),
            .b        (b_src[CHUNK-1:0]),
            .c_in     (carry_src),
            .sum      (slice_sum),
            .c_out    (slice_c_out),
            .msb_c_in (msb_cin)
        );

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sum_q   <= {SUM_W{SUM_RESET_BIT}};
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (adv) begin
                sum_q   <= sum_next;
                carry_q <= slice_c_out;
                valid_q <= valid_src;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [SRC_W-CHUNK-1:0] a_q;
            logic [SRC_W-CHUNK-1:0] b_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[SRC_W-1:CHUNK];
                    b_q <= b_src[SRC_W-1:CHUNK];
                end
            end
        end

`ifdef ADDER_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= msb_cin ^ slice_c_out;
                end
            end
        end else begin : g_no_ovf
            logic unused_msb_cin;
            assign unused_msb_cin = msb_cin;
        end
`else
        logic unused_msb_cin;
        assign unused_msb_cin = msb_cin;
`endif
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign c_out     = g_stage[STAGES-1].carry_q;
`ifdef ADDER_OVERFLOW_EN
    assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
